bp: RTL and testbench
=====================

Name: bp

Overview:
- Branch predictor directly upstream of the instruction fetch unit.
- Combinationally predicts the next fetch PC and taken flag for the current fetch PC. These feed the IFU's next_pc_i and next_taken_i.
- Direct-mapped BTB with 2-bit saturating counters. Trained non-speculatively by branch resolution from EX.

Parameters:
- ADDR_W, 32, PC width (matches instruction address bus).
- IDX_W, 6, log2 of table entries (64 entries).
- GHR_W, 6, global history length; must be <= IDX_W; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- n_rst_i  in  1  asynchronous, active-low reset.
- pc_i  in  ADDR_W  current fetch PC (IFU pc_o).
- next_pc_o  out  ADDR_W  predicted next fetch PC.
- next_taken_o  out  1  prediction is taken.
- pred_ghr_o  out  GHR_W  GHR value used for this lookup, carried down the pipe to EX.
- upd_valid_i  in  1  EX resolved a conditional branch/jump this cycle.
- upd_pc_i  in  ADDR_W  PC of resolved branch.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_ghr_i  in  GHR_W  pred_ghr_o value that travelled with that branch.
- upd_mispredict_i  in  1  EX redirected, i.e. branch_redirect asserted.

Behaviour:
- Reset is asynchronous, active-low; all storage clears immediately:
  - valid[ ] = 0, ctr[ ] = 2'b01, tag/target = 0, GHR = 0.
  - Outputs are then next_pc_o = pc_i+4, next_taken_o = 0.
- Lookup is combinational, zero latency:
  - idx = pc_i[IDX_W+1:2]; tag = pc_i[ADDR_W-1:IDX_W+2].
  - hit = valid[idx] && tag[idx]==tag.
  - next_taken_o = hit && ctr[idx][1].
  - next_pc_o = next_taken_o ? target[idx] : pc_i+4. The +4 wraps modulo 2^ADDR_W with no carry out.
  - pred_ghr_o = GHR (0 when feature off).
- Update is on the clock edge when upd_valid_i=1, using uidx/utag computed from upd_pc_i.
- Hit at uidx:
  - ctr saturating +1 if taken, -1 if not taken. 2'b11 stays on taken; 2'b00 stays on not taken.
  - If taken, target overwritten with upd_target_i.
- Miss, taken:
  - Allocate/replace entry: valid=1, tag=utag, target=upd_target_i, ctr=2'b10.
- Miss, not taken: no table change.
- Lookup and update of the same index in the same cycle: lookup returns pre-update contents (no bypass). The new value is visible the following cycle.
- upd_valid_i=0: tables and GHR hold.
- Stalls have no effect on the predictor. The IFU owns stall/flush; updates from EX are always accepted.
- upd_mispredict_i is informational when the feature is off. No table action is taken beyond the normal update.
- Reset mid-update: reset wins; the in-flight update is discarded.
- pc_i misaligned (bits[1:0]≠0): bits ignored for index; prediction still produced.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined (gshare indexing):
  - Lookup idx = pc_i[IDX_W+1:2] XOR zero-extended GHR.
  - Update idx = upd_pc_i[IDX_W+1:2] XOR zero-extended upd_ghr_i.
  - On upd_valid_i, GHR <= {upd_ghr_i[GHR_W-2:0], upd_taken_i}. This is non-speculative and repairs history after mispredicts.
  - Tag compare unchanged.
- Undefined:
  - GHR removed, pred_ghr_o tied to 0, upd_ghr_i ignored.
  - Pure PC indexing.

Test Plan:
- Reset: n_rst_i low, pc_i=0x0000_1000 -> next_pc_o=0x0000_1004, next_taken_o=0. Release reset: unchanged, no hits.
- Cold allocate: update pc=0x1000, taken=1, target=0x2000 -> next cycle, pc_i=0x1000 gives next_pc_o=0x2000, next_taken_o=1 (ctr=10).
- Hysteresis: after allocate, two not-taken updates at 0x1000 -> after the first still predicts taken? No: ctr goes 10->01, so not taken after the first. A second update saturates at 00. Then two taken updates are required before taken (00->01->10).
- Aliasing: allocate 0x1000, then pc_i=0x1100 (same idx, different tag) -> miss, next_pc_o=0x1104, next_taken_o=0.
- Same-cycle lookup/update on idx of 0x1000 -> output reflects old entry that cycle and new entry the next.
- With BP_GSHARE_EN: upd_ghr_i=6'b000001, taken=1 at pc 0x1000 -> GHR=6'b000011. Lookup at 0x1000 hits only when GHR=6'b000001 XOR-aliasing matches; pred_ghr_o tracks GHR.

Source files
------------

// File: rtl/bp.sv
// -----------------------------------------------------------------------------
// bp : branch predictor sitting directly upstream of the instruction fetch unit.
//
// A direct-mapped branch target buffer with 2-bit saturating counters. Lookup is
// purely combinational (zero latency) from the current fetch PC. Training comes
// non-speculatively from branch resolution in EX and is applied on the clock
// edge. A lookup and an update of the same entry in the same cycle see the old
// contents; the new contents are visible the following cycle.
//
// Optional feature (macro BP_GSHARE_EN):
//   undefined : pure PC indexing, no global history, pred_ghr_o tied to 0,
//               upd_ghr_i ignored.
//   defined   : gshare indexing, where the index is the PC index XOR the
//               zero-extended global history. The history register is rebuilt
//               from the history that travelled with each resolved branch, so
//               it self-repairs after mispredicts.
//
// Ports:
//   clk_i            clock
//   n_rst_i          asynchronous active-low reset, clears all tables and history
//   pc_i             current fetch PC
//   next_pc_o        predicted next fetch PC
//   next_taken_o     prediction is taken
//   pred_ghr_o       history used for this lookup, carried down the pipe
//   upd_valid_i      EX resolved a conditional branch/jump this cycle
//   upd_pc_i         PC of the resolved branch
//   upd_taken_i      actual outcome
//   upd_target_i     actual taken target
//   upd_ghr_i        pred_ghr_o value that travelled with that branch
//   upd_mispredict_i EX redirected (informational only)
// -----------------------------------------------------------------------------
module bp #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int GHR_W  = 6
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              next_taken_o,
  output logic [GHR_W-1:0]  pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic [GHR_W-1:0]  upd_ghr_i,
  input  logic              upd_mispredict_i
);

  localparam int TAG_W   = ADDR_W - IDX_W - 2;
  localparam int ENTRIES = 1 << IDX_W;

  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;

  logic              upd_we;
  logic [1:0]        upd_ctr_d;
  logic [TAG_W-1:0]  upd_tag_d;
  logic [ADDR_W-1:0] upd_tgt_d;

  logic              unused_w;

  assign lk_tag = pc_i[ADDR_W-1:IDX_W+2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;

  // History is XORed into the low index bits; GHR_W <= IDX_W so the cast zero-extends.
  assign lk_idx     = pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign up_idx     = upd_pc_i[IDX_W+1:2] ^ IDX_W'(upd_ghr_i);
  assign pred_ghr_o = ghr_q;

  // Rebuilt from the history carried with the resolved branch, not from the
  // local register, so a wrong-path history is overwritten automatically.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i) begin
      ghr_d = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign unused_w = ^{pc_i[1:0], upd_pc_i[1:0], upd_mispredict_i};
`else
  assign lk_idx     = pc_i[IDX_W+1:2];
  assign up_idx     = upd_pc_i[IDX_W+1:2];
  assign pred_ghr_o = '0;

  assign unused_w = ^{pc_i[1:0], upd_pc_i[1:0], upd_mispredict_i, upd_ghr_i};
`endif

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // +4 wraps naturally at the top of the address space.
  assign next_taken_o = lk_hit && ctr_q[lk_idx][1];
  assign next_pc_o    = next_taken_o ? target_q[lk_idx] : (pc_i + ADDR_W'(4));

  // Next contents of the single entry being trained. A miss that resolved
  // not-taken leaves the table alone so it cannot evict a useful entry.
  always_comb begin
    upd_we    = 1'b0;
    upd_ctr_d = ctr_q[up_idx];
    upd_tag_d = tag_q[up_idx];
    upd_tgt_d = target_q[up_idx];
    if (upd_valid_i) begin
      if (up_hit) begin
        upd_we = 1'b1;
        if (upd_taken_i) begin
          if (ctr_q[up_idx] != 2'b11) begin
            upd_ctr_d = ctr_q[up_idx] + 2'b01;
          end
          upd_tgt_d = upd_target_i;
        end else if (ctr_q[up_idx] != 2'b00) begin
          upd_ctr_d = ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken_i) begin
        upd_we    = 1'b1;
        upd_ctr_d = 2'b10;
        upd_tag_d = up_tag;
        upd_tgt_d = upd_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (upd_we) begin
      valid_q[up_idx]  <= 1'b1;
      ctr_q[up_idx]    <= upd_ctr_d;
      tag_q[up_idx]    <= upd_tag_d;
      target_q[up_idx] <= upd_tgt_d;
    end
  end

endmodule

// File: tb/tb_bp.sv
// -----------------------------------------------------------------------------
// tb_bp : directed, table-driven bench for the bp branch predictor.
// Each table row drives one lookup PC plus (optionally) one EX update, checks
// the combinational prediction before the clock edge (so same-cycle updates
// must not be visible yet), then lets the edge commit the update.
// -----------------------------------------------------------------------------
module tb_bp;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam int GHR_W  = 6;

  logic              clk_i = 1'b0;
  logic              n_rst_i;
  logic [ADDR_W-1:0] pc_i;
  logic [ADDR_W-1:0] next_pc_o;
  logic              next_taken_o;
  logic [GHR_W-1:0]  pred_ghr_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic [GHR_W-1:0]  upd_ghr_i;
  logic              upd_mispredict_i;

  int compared   = 0;
  int mismatched = 0;

  bp #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .GHR_W(GHR_W)) dut (
    .clk_i            (clk_i),
    .n_rst_i          (n_rst_i),
    .pc_i             (pc_i),
    .next_pc_o        (next_pc_o),
    .next_taken_o     (next_taken_o),
    .pred_ghr_o       (pred_ghr_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_ghr_i        (upd_ghr_i),
    .upd_mispredict_i (upd_mispredict_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] lpc;
    logic [31:0] expPc;
    logic        expTaken;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic [31:0] lpc,
                        input logic [31:0] expPc, input logic expTaken);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.lpc = lpc; v.expPc = expPc; v.expTaken = expTaken;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expPc,
                             input logic expTaken, input logic [GHR_W-1:0] expGhr);
    checkVal({name, " next_pc"}, next_pc_o, expPc);
    checkVal({name, " taken"}, {31'd0, next_taken_o}, {31'd0, expTaken});
    checkVal({name, " ghr"}, {26'd0, pred_ghr_o}, {26'd0, expGhr});
  endtask

  task automatic applyStimulus(input logic uv, input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic [GHR_W-1:0] ughr,
                               input logic [31:0] lpc);
    upd_valid_i      = uv;
    upd_pc_i         = upc;
    upd_taken_i      = ut;
    upd_target_i     = utgt;
    upd_ghr_i        = ughr;
    upd_mispredict_i = uv;
    pc_i             = lpc;
  endtask

  initial begin
    n_rst_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 32'h0000_1000);
    #1;
    checkOutput("reset_held", 32'h0000_1004, 1'b0, 6'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("reset_released", 32'h0000_1004, 1'b0, 6'd0);

`ifndef BP_GSHARE_EN
    // 0x1000 and 0x1100 share index 0 with tags 0x10 / 0x11.
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1000, 32'h0000_1004, 1'b0);
    addVec(1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_1000, 32'h0000_1004, 1'b0);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1000, 32'h0000_2000, 1'b1);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1100, 32'h0000_1104, 1'b0);
    addVec(1'b1, 32'h0000_1000, 1'b0, 32'h0,         32'h0000_1000, 32'h0000_2000, 1'b1);
    addVec(1'b1, 32'h0000_1000, 1'b0, 32'h0,         32'h0000_1000, 32'h0000_1004, 1'b0);
    addVec(1'b1, 32'h0000_1000, 1'b1, 32'h0000_3000, 32'h0000_1000, 32'h0000_1004, 1'b0);
    addVec(1'b1, 32'h0000_1000, 1'b1, 32'h0000_3000, 32'h0000_1000, 32'h0000_1004, 1'b0);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1000, 32'h0000_3000, 1'b1);
    addVec(1'b1, 32'h0000_1000, 1'b1, 32'h0000_3000, 32'h0000_1000, 32'h0000_3000, 1'b1);
    addVec(1'b1, 32'h0000_1000, 1'b1, 32'h0000_3000, 32'h0000_1000, 32'h0000_3000, 1'b1);
    addVec(1'b1, 32'h0000_1000, 1'b0, 32'h0,         32'h0000_1000, 32'h0000_3000, 1'b1);
    addVec(1'b1, 32'h0000_1000, 1'b0, 32'h0,         32'h0000_1000, 32'h0000_3000, 1'b1);
    addVec(1'b1, 32'h0000_1000, 1'b1, 32'h0000_4000, 32'h0000_1000, 32'h0000_1004, 1'b0);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1003, 32'h0000_4000, 1'b1);
    addVec(1'b0, 32'h0000_1000, 1'b0, 32'h0,         32'h0000_1000, 32'h0000_4000, 1'b1);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1000, 32'h0000_4000, 1'b1);
    addVec(1'b1, 32'h0000_1100, 1'b0, 32'h0,         32'h0000_1100, 32'h0000_1104, 1'b0);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1100, 32'h0000_1104, 1'b0);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1000, 32'h0000_4000, 1'b1);
    addVec(1'b1, 32'h0000_1100, 1'b1, 32'h0000_5000, 32'h0000_1100, 32'h0000_1104, 1'b0);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1100, 32'h0000_5000, 1'b1);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1000, 32'h0000_1004, 1'b0);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
    addVec(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0100, 1'b1);
    addVec(1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0004, 32'h0000_0008, 1'b0);

    foreach (vecs[i]) begin
      @(posedge clk_i);
      #1;
      applyStimulus(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, 6'd0, vecs[i].lpc);
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expTaken, 6'd0);
    end

    // Asynchronous reset while an allocating update is pending: tables clear
    // immediately and the pending update is discarded.
    @(posedge clk_i);
    #1;
    applyStimulus(1'b1, 32'h0000_1100, 1'b1, 32'h0000_6000, 6'd0, 32'h0000_1100);
    #2;
    n_rst_i = 1'b0;
    #1;
    checkOutput("async_reset_clear", 32'h0000_1104, 1'b0, 6'd0);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 32'h0000_1100);
    n_rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("reset_drops_update", 32'h0000_1104, 1'b0, 6'd0);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 32'hFFFF_FFFC);
    @(negedge clk_i);
    checkOutput("reset_clears_other", 32'h0000_0000, 1'b0, 6'd0);
`else
    // Taken update with history 000001 lands at index 0^1 = 1 and sets GHR to 000011.
    @(posedge clk_i);
    #1;
    applyStimulus(1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 6'b000001, 32'h0000_1000);
    @(negedge clk_i);
    checkOutput("gs_cold", 32'h0000_1004, 1'b0, 6'b000000);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 32'h0000_1000);
    @(negedge clk_i);
    checkOutput("gs_ghr3_miss", 32'h0000_1004, 1'b0, 6'b000011);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 32'h0000_1000);
    @(negedge clk_i);
    checkOutput("gs_ghr_hold", 32'h0000_1004, 1'b0, 6'b000011);
    // Taken at 0x2000 with history 0 allocates index 0 (tag 0x20) and sets GHR to 000001.
    @(posedge clk_i);
    #1;
    applyStimulus(1'b1, 32'h0000_2000, 1'b1, 32'h0000_7000, 6'b000000, 32'h0000_1000);
    @(negedge clk_i);
    checkOutput("gs_retrain", 32'h0000_1004, 1'b0, 6'b000011);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 32'h0000_1000);
    @(negedge clk_i);
    checkOutput("gs_ghr1_hit", 32'h0000_2000, 1'b1, 6'b000001);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 32'h0000_1004);
    @(negedge clk_i);
    checkOutput("gs_tag_miss", 32'h0000_1008, 1'b0, 6'b000001);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 32'h0000_2004);
    @(negedge clk_i);
    checkOutput("gs_hit_idx0", 32'h0000_7000, 1'b1, 6'b000001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
